// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache tag block: FSM states and
// tree-PLRU select/update helpers sized for up to 8 ways.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MISS  = 2'd1,
        ST_FLUSH = 2'd2
    } icache_state_e;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit=0 points left.
    function automatic logic [2:0] plru_select(input logic [6:0] bits, input int levels);
        int         node;
        logic [2:0] way;
        node = 0;
        way  = '0;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                way  = {way[1:0], bits[node[2:0]]};
                node = 2 * node + 1 + int'(bits[node[2:0]]);
            end
        end
        return way;
    endfunction

    function automatic logic [6:0] plru_update(input logic [6:0] bits, input logic [2:0] way,
                                               input int levels);
        logic [6:0] r;
        int         node;
        logic       dir;
        r    = bits;
        node = 0;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                dir              = way[3'(levels - 1 - l)];
                r[node[2:0]]     = ~dir;
                node             = 2 * node + 1 + int'(dir);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icache_tag_nway_plru_tree.sv
// Tree-PLRU for one set: victim for the current bits, and the bits after an
// access to access_i (pointing away from it).
module plru_tree
    import icache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [WAYS-2:0]         bits_i,
    input  logic [$clog2(WAYS)-1:0] access_i,
    output logic [$clog2(WAYS)-1:0] victim_o,
    output logic [WAYS-2:0]         bits_o
);
    localparam int LW = $clog2(WAYS);

    logic [6:0] bits_ext, upd_ext;
    logic [2:0] acc_ext, sel_ext;

    always_comb begin
        bits_ext            = '0;
        bits_ext[WAYS-2:0]  = bits_i;
        acc_ext             = '0;
        acc_ext[LW-1:0]     = access_i;
        sel_ext             = plru_select(bits_ext, LW);
        upd_ext             = plru_update(bits_ext, acc_ext, LW);
    end

    assign victim_o = sel_ext[LW-1:0];
    assign bits_o   = upd_ext[WAYS-2:0];

endmodule

// File: rtl/icache_tag_nway.sv
// N-way set-associative I-cache tag array with miss latch, tree-PLRU
// replacement and a set-per-cycle fence.i flush walker.
module icache_tag_nway
    import icache_pkg::*;
#(
    parameter int WAYS     = 2,
    parameter int SETS     = 64,
    parameter int OFFSET_W = 3,
    parameter int ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_cacheable,
    input  logic              kill,
    input  logic              fence_i,
    input  logic              refill_done,
    output logic              hit,
    output logic [WAYS-1:0]   hit_way,
    output logic              miss_req,
    output logic [ADDR_W-1:0] miss_addr,
    output logic [WAYS-1:0]   victim_way,
    output logic              stallreq
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFFSET_W;
    localparam int WIDX_W = $clog2(WAYS);

    icache_state_e             state_q;
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-2:0] plru_q;
    logic [TAG_W-1:0]          tag_q [SETS][WAYS];
    logic [IDX_W-1:0]          flush_cnt_q;
    logic                      fence_pending_q;
    logic [ADDR_W-1:0]         miss_addr_q;
    logic [WAYS-1:0]           victim_way_q;
    logic [WIDX_W-1:0]         victim_idx_q;

    logic [IDX_W-1:0]  req_idx, miss_idx, plru_set;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic              lookup_en, new_miss, any_invalid, refill_we;
    logic [WIDX_W-1:0] hit_idx, alloc_idx, plru_victim, plru_acc, victim_idx;
    logic [WAYS-2:0]   plru_upd;

    assign req_idx   = req_addr[OFFSET_W +: IDX_W];
    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign miss_idx  = miss_addr_q[OFFSET_W +: IDX_W];
    assign miss_tag  = miss_addr_q[ADDR_W-1 -: TAG_W];
    assign lookup_en = req_valid & req_cacheable & (state_q == ST_IDLE);
    assign refill_we = (state_q == ST_MISS) & refill_done;

    // Descending scan so the lowest-index invalid way wins allocation.
    always_comb begin
        hit_way     = '0;
        hit_idx     = '0;
        alloc_idx   = '0;
        any_invalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lookup_en && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_way[w] = 1'b1;
                hit_idx    = WIDX_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                any_invalid = 1'b1;
                alloc_idx   = WIDX_W'(w);
            end
        end
    end

    assign hit        = |hit_way;
    assign new_miss   = lookup_en & ~hit & ~kill;
    assign victim_idx = any_invalid ? alloc_idx : plru_victim;

    // One PLRU tree serves both the hit update (IDLE) and the refill update (MISS).
    assign plru_set = (state_q == ST_MISS) ? miss_idx : req_idx;
    assign plru_acc = (state_q == ST_MISS) ? victim_idx_q : hit_idx;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_i   (plru_q[plru_set]),
        .access_i (plru_acc),
        .victim_o (plru_victim),
        .bits_o   (plru_upd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            fence_pending_q <= 1'b0;
            flush_cnt_q     <= '0;
            miss_addr_q     <= '0;
            victim_way_q    <= '0;
            victim_idx_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fence_i) begin
                        state_q <= ST_FLUSH;
                    end else if (new_miss) begin
                        state_q      <= ST_MISS;
                        miss_addr_q  <= {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        victim_idx_q <= victim_idx;
                        victim_way_q <= {{(WAYS-1){1'b0}}, 1'b1} << victim_idx;
                    end
                end
                ST_MISS: begin
                    if (fence_i) fence_pending_q <= 1'b1;
                    if (refill_done) begin
                        state_q         <= (fence_pending_q || fence_i) ? ST_FLUSH : ST_IDLE;
                        fence_pending_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                    if (flush_cnt_q == IDX_W'(SETS - 1)) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else if (state_q == ST_FLUSH) begin
            valid_q[flush_cnt_q] <= '0;
            plru_q[flush_cnt_q]  <= '0;
        end else if (refill_we) begin
            valid_q[miss_idx][victim_idx_q] <= 1'b1;
            plru_q[miss_idx]                <= plru_upd;
        end else if (hit) begin
            plru_q[req_idx] <= plru_upd;
        end
    end

    // Tags need no reset: a way is only consulted when its valid bit is set.
    always_ff @(posedge clk) begin
        if (refill_we) tag_q[miss_idx][victim_idx_q] <= miss_tag;
    end

    assign miss_req   = (state_q == ST_MISS);
    assign miss_addr  = miss_addr_q;
    assign victim_way = victim_way_q;
    assign stallreq   = new_miss | (state_q == ST_MISS) | (state_q == ST_FLUSH) | fence_pending_q;

endmodule

// File: tb/tb_icache_tag_nway.sv
// Directed bench: a 4-way and a 2-way instance share one stimulus stream.
module tb_icache_tag_nway;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_cacheable, kill, fence_i, refill_done;
    logic [63:0] req_addr;

    logic        hit4, miss_req4, stall4;
    logic [3:0]  hw4, vw4;
    logic [63:0] ma4;
    logic        hit2, miss_req2, stall2;
    logic [1:0]  hw2, vw2;
    logic [63:0] ma2;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [63:0] A = 64'h8000_0000, B = 64'h8000_0200, C = 64'h8000_0400;
    localparam logic [63:0] D = 64'h8000_0600, E = 64'h8000_0800, F = 64'h8000_0048;

    always #5 clk = ~clk;

    icache_tag_nway #(.WAYS(4), .SETS(64), .OFFSET_W(3), .ADDR_W(64)) u4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_cacheable(req_cacheable), .kill(kill), .fence_i(fence_i),
        .refill_done(refill_done), .hit(hit4), .hit_way(hw4), .miss_req(miss_req4),
        .miss_addr(ma4), .victim_way(vw4), .stallreq(stall4));

    icache_tag_nway #(.WAYS(2), .SETS(64), .OFFSET_W(3), .ADDR_W(64)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_cacheable(req_cacheable), .kill(kill), .fence_i(fence_i),
        .refill_done(refill_done), .hit(hit2), .hit_way(hw2), .miss_req(miss_req2),
        .miss_addr(ma2), .victim_way(vw2), .stallreq(stall2));

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; req_cacheable = 1'b0; kill = 1'b0;
        fence_i = 1'b0; refill_done = 1'b0; req_addr = '0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic fill(input logic [63:0] a);
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = a;
        cycle();
        req_valid = 1'b0; refill_done = 1'b1;
        cycle();
        refill_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++; if ({hit4, hw4, miss_req4, vw4, stall4} !== 11'd0) begin n_fail++; $display("FAIL reset_outs4: got %b want 0", {hit4, hw4, miss_req4, vw4, stall4}); end
        n_chk++; if ({hit2, hw2, miss_req2, vw2, stall2} !== 7'd0) begin n_fail++; $display("FAIL reset_outs2: got %b want 0", {hit2, hw2, miss_req2, vw2, stall2}); end
        n_chk++; if (ma4 !== 64'd0) begin n_fail++; $display("FAIL reset_miss_addr: got %h want 0", ma4); end
    endtask

    task automatic test_miss_refill();
        do_reset();
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = A;
        #1;
        n_chk++; if ({hit4, stall4} !== 2'b01) begin n_fail++; $display("FAIL lookup_new_miss: got hit,stall=%b want 01", {hit4, stall4}); end
        cycle();
        n_chk++; if ({miss_req4, stall4, hit4} !== 3'b110) begin n_fail++; $display("FAIL miss_state: got req,stall,hit=%b want 110", {miss_req4, stall4, hit4}); end
        n_chk++; if (ma4 !== A) begin n_fail++; $display("FAIL miss_addr: got %h want %h", ma4, A); end
        n_chk++; if (vw4 !== 4'b0001) begin n_fail++; $display("FAIL victim4_first: got %b want 0001", vw4); end
        n_chk++; if (vw2 !== 2'b01) begin n_fail++; $display("FAIL victim2_first: got %b want 01", vw2); end
        refill_done = 1'b1;
        cycle();
        refill_done = 1'b0;
        n_chk++; if ({hit4, hw4, stall4, miss_req4} !== 7'b1_0001_00) begin n_fail++; $display("FAIL hit_after_refill4: got %b want 1000100", {hit4, hw4, stall4, miss_req4}); end
        n_chk++; if ({hit2, hw2} !== 3'b1_01) begin n_fail++; $display("FAIL hit_after_refill2: got %b want 101", {hit2, hw2}); end
        req_valid = 1'b0;
    endtask

    task automatic test_plru_2way();
        do_reset();
        fill(A);
        fill(B);
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = A;
        #1;
        n_chk++; if ({hit2, hw2} !== 3'b1_01) begin n_fail++; $display("FAIL plru_hitA: got %b want 101", {hit2, hw2}); end
        cycle();
        req_addr = C;
        #1;
        n_chk++; if (hit2 !== 1'b0) begin n_fail++; $display("FAIL plru_C_lookup: got %b want 0", hit2); end
        cycle();
        req_valid = 1'b0;
        n_chk++; if ({miss_req2, vw2} !== 3'b1_10) begin n_fail++; $display("FAIL plru_victim2: got %b want 110", {miss_req2, vw2}); end
        n_chk++; if ({miss_req4, vw4} !== 5'b1_0100) begin n_fail++; $display("FAIL alloc_victim4: got %b want 10100", {miss_req4, vw4}); end
        refill_done = 1'b1;
        cycle();
        refill_done = 1'b0;
        req_valid = 1'b1; req_addr = C;
        #1;
        n_chk++; if ({hit2, hw2, hit4, hw4} !== 8'b1_10_1_0100) begin n_fail++; $display("FAIL refilled_C: got %b want 11010100", {hit2, hw2, hit4, hw4}); end
        req_addr = B;
        #1;
        n_chk++; if ({hit2, hit4, hw4} !== 6'b0_1_0010) begin n_fail++; $display("FAIL evicted_B: got %b want 010010", {hit2, hit4, hw4}); end
        req_valid = 1'b0;
    endtask

    task automatic test_plru_4way();
        do_reset();
        fill(A); fill(B); fill(C); fill(D);
        // kill blocks the 2-way miss on A but not the 4-way hit / PLRU update
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = A; kill = 1'b1;
        #1;
        n_chk++; if ({hit4, hw4, hit2, stall2} !== 7'b1_0001_00) begin n_fail++; $display("FAIL kill_hit4: got %b want 1000100", {hit4, hw4, hit2, stall2}); end
        cycle();
        kill = 1'b0; req_addr = E;
        cycle();
        req_valid = 1'b0;
        n_chk++; if ({miss_req4, vw4} !== 5'b1_0100) begin n_fail++; $display("FAIL plru_victim4: got %b want 10100", {miss_req4, vw4}); end
        n_chk++; if (miss_req2 !== 1'b1) begin n_fail++; $display("FAIL miss2_E: got %b want 1", miss_req2); end
    endtask

    task automatic test_fence();
        int cnt;
        do_reset();
        fill(A);
        fill(F);
        fence_i = 1'b1;
        #1;
        n_chk++; if (stall4 !== 1'b0) begin n_fail++; $display("FAIL fence_cycle_stall: got %b want 0", stall4); end
        cycle();
        fence_i = 1'b0;
        cnt = 0;
        while (stall4 && cnt < 200) begin
            fence_i = (cnt == 10); refill_done = (cnt == 10);
            cycle();
            fence_i = 1'b0; refill_done = 1'b0;
            cnt++;
        end
        n_chk++; if (cnt !== 64) begin n_fail++; $display("FAIL flush_len: got %0d cycles want 64", cnt); end
        n_chk++; if ({stall2, miss_req4} !== 2'b00) begin n_fail++; $display("FAIL flush_done: got %b want 00", {stall2, miss_req4}); end
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = A;
        #1;
        n_chk++; if ({hit4, hit2, stall4} !== 3'b001) begin n_fail++; $display("FAIL flushed_A: got %b want 001", {hit4, hit2, stall4}); end
        req_addr = F;
        #1;
        n_chk++; if ({hit4, hit2} !== 2'b00) begin n_fail++; $display("FAIL flushed_F: got %b want 00", {hit4, hit2}); end
        req_valid = 1'b0;
    endtask

    task automatic test_fence_in_miss();
        int cnt;
        do_reset();
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = A;
        cycle();
        req_valid = 1'b0; fence_i = 1'b1;
        cycle();
        fence_i = 1'b0;
        n_chk++; if ({miss_req4, stall4} !== 2'b11) begin n_fail++; $display("FAIL fence_in_miss: got %b want 11", {miss_req4, stall4}); end
        refill_done = 1'b1;
        cycle();
        refill_done = 1'b0;
        cnt = 0;
        while (stall4 && cnt < 200) begin
            cycle();
            cnt++;
        end
        n_chk++; if (cnt !== 64) begin n_fail++; $display("FAIL pending_flush_len: got %0d cycles want 64", cnt); end
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = A;
        #1;
        n_chk++; if ({hit4, hit2} !== 2'b00) begin n_fail++; $display("FAIL refilled_then_flushed: got %b want 00", {hit4, hit2}); end
        req_valid = 1'b0;
    endtask

    task automatic test_uncacheable_kill();
        do_reset();
        req_valid = 1'b1; req_cacheable = 1'b0; req_addr = 64'h1000_0000;
        #1;
        n_chk++; if ({hit4, miss_req4, stall4} !== 3'b000) begin n_fail++; $display("FAIL uncacheable: got %b want 000", {hit4, miss_req4, stall4}); end
        cycle();
        n_chk++; if ({miss_req4, stall4, miss_req2} !== 3'b000) begin n_fail++; $display("FAIL uncacheable_next: got %b want 000", {miss_req4, stall4, miss_req2}); end
        req_cacheable = 1'b1; req_addr = A; kill = 1'b1;
        #1;
        n_chk++; if (stall4 !== 1'b0) begin n_fail++; $display("FAIL kill_stall: got %b want 0", stall4); end
        cycle();
        n_chk++; if (miss_req4 !== 1'b0) begin n_fail++; $display("FAIL kill_idle: got %b want 0", miss_req4); end
        kill = 1'b0;
        #1;
        n_chk++; if (stall4 !== 1'b1) begin n_fail++; $display("FAIL unkilled_stall: got %b want 1", stall4); end
        cycle();
        kill = 1'b1;
        cycle();
        n_chk++; if (miss_req4 !== 1'b1) begin n_fail++; $display("FAIL kill_in_miss: got %b want 1", miss_req4); end
        kill = 1'b0; refill_done = 1'b1;
        cycle();
        refill_done = 1'b0;
        n_chk++; if ({hit4, hw4} !== 5'b1_0001) begin n_fail++; $display("FAIL kill_refill_hit: got %b want 10001", {hit4, hw4}); end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = A;
        cycle();
        req_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_chk++; if ({miss_req4, stall4, vw4} !== 6'd0) begin n_fail++; $display("FAIL rst_mid_miss: got %b want 0", {miss_req4, stall4, vw4}); end
        n_chk++; if (ma4 !== 64'd0) begin n_fail++; $display("FAIL rst_miss_addr: got %h want 0", ma4); end
        refill_done = 1'b1;
        cycle();
        refill_done = 1'b0;
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = A;
        #1;
        n_chk++; if ({hit4, hit2} !== 2'b00) begin n_fail++; $display("FAIL stale_refill: got %b want 00", {hit4, hit2}); end
        req_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 1'b1; req_cacheable = 1'b1; req_addr = 64'h8000_0106;
        cycle();
        req_valid = 1'b0;
        n_chk++; if (ma4 !== 64'h8000_0100) begin n_fail++; $display("FAIL offset_zeroed: got %h want 8000_0100", ma4); end
        refill_done = 1'b1;
        cycle();
        refill_done = 1'b0;
        fill(A);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_cacheable = 1'b1;
            req_addr = (i % 2 == 0) ? 64'h8000_0101 : 64'h8000_0007;
            #1;
            n_chk++; if ({hit4, hw4, stall4} !== 6'b1_0001_0) begin n_fail++; $display("FAIL b2b_hit%0d: got %b want 100010", i, {hit4, hw4, stall4}); end
            cycle();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_miss_refill();
        test_plru_2way();
        test_plru_4way();
        test_fence();
        test_fence_in_miss();
        test_uncacheable_kill();
        test_reset_mid_miss();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_tag_nway.md
ICACHE_TAG_NWAY -- requirements
Module: icache_tag_nway

Interface
REQ-001 Parameter WAYS, default 2, number of ways (power of two, 2..8).
REQ-002 Parameter SETS, default 64, number of sets (power of two).
REQ-003 Parameter OFFSET_W, default 3, line-offset bits.
REQ-004 Parameter ADDR_W, default 64, address width; TAG_W = ADDR_W - log2(SETS) - OFFSET_W.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  fetch lookup request.
REQ-008 req_addr  in  ADDR_W  fetch address {tag, index, offset}.
REQ-009 req_cacheable  in  1  address is in a cacheable region.
REQ-010 kill  in  1  pipeline flush; suppresses a new miss this cycle.
REQ-011 fence_i  in  1  one-cycle pulse, invalidate all lines.
REQ-012 refill_done  in  1  one-cycle pulse, data array has written the missed line.
REQ-013 hit  out  1  lookup hit.
REQ-014 hit_way  out  WAYS  one-hot hitting way.
REQ-015 miss_req  out  1  high in MISS state; refill engine fetches miss_addr.
REQ-016 miss_addr  out  ADDR_W  latched missing address, offset bits zeroed.
REQ-017 victim_way  out  WAYS  one-hot way being refilled, stable through MISS.
REQ-018 stallreq  out  1  stall fetch stage.

Function
REQ-019 Per set per way: valid bit plus TAG_W tag; per set: WAYS-1 tree-PLRU bits.
REQ-020 Lookup is combinational: way hits when req_valid & req_cacheable & state==IDLE & valid & stored tag == req_addr tag.
REQ-021 At most one way hits; hit = OR of hit_way.
REQ-022 Hit: PLRU bits of that set updated at the next clk edge to point away from the hitting way.
REQ-023 States: IDLE, MISS, FLUSH; one-hot or binary, encoding free.
REQ-024 IDLE -> MISS when req_valid & req_cacheable & ~hit & ~kill; miss_addr and victim_way latched that edge.
REQ-025 Victim: lowest-index invalid way in the set; if all valid, the PLRU-selected way.
REQ-026 MISS: miss_req=1, stallreq=1; lookups do not hit; kill ignored (refill always completes).
REQ-027 MISS & refill_done: write {valid=1, tag} into victim_way of latched index, update PLRU away from victim, return to IDLE (or FLUSH if fence pending).
REQ-028 Uncacheable request: hit=0, no miss, no state change, stallreq=0.
REQ-029 fence_i in IDLE -> FLUSH; in MISS -> set fence_pending, enter FLUSH after refill.
REQ-030 FLUSH: counter 0..SETS-1 clears all valid bits and PLRU bits of one set per cycle; exactly SETS cycles; stallreq=1; then IDLE.
REQ-031 fence_i during FLUSH is absorbed (no restart); refill_done outside MISS is ignored.
REQ-032 stallreq = (IDLE & new miss condition) | MISS | FLUSH | fence_pending.

Reset
REQ-033 rst clears all valid bits, PLRU bits, fence_pending, flush counter; state=IDLE.
REQ-034 After reset: hit=0, hit_way=0, miss_req=0, miss_addr=0, victim_way=0, stallreq=0 (absent a request).
REQ-035 rst mid-MISS or mid-FLUSH aborts immediately; a later refill_done has no effect.

Structure
REQ-036 State encoding and PLRU update/select functions in shared package icache_pkg.
REQ-037 One sub-module plru_tree (WAYS param): given set bits, outputs victim and updated bits for an access way.
REQ-038 Tag/valid storage in flops; no SRAM macro.

Verification
REQ-039 Reset, lookup 0x8000_0000 cacheable -> miss_req=1, miss_addr=0x8000_0000, victim_way=0001 (WAYS=4); refill_done -> next lookup hit, hit_way=0001.
REQ-040 WAYS=2, fill 0x8000_0000 and 0x8000_0200 (same index), hit first, miss 0x8000_0400 -> victim_way=10.
REQ-041 fence_i after fills -> stallreq high exactly SETS=64 cycles, then all prior addresses miss.
REQ-042 fence_i during MISS -> refill completes, FLUSH follows, refilled line invalidated afterward.
REQ-043 Uncacheable 0x1000_0000 -> hit=0, miss_req=0, stallreq=0; kill with cacheable miss -> stays IDLE.
REQ-044 rst asserted mid-MISS -> IDLE, miss_req=0; subsequent refill_done -> no line valid.
